// File: rtl/expected_checker.sv
// Scoreboard end stage: compares the delayed expected stream against the DUT
// stream, counts checks and errors, and holds the first failing pair for debug.
module expected_checker #(
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned COUNT_BITS    = 32,
    parameter string       STOP_ON_ERROR = "false",
    parameter string       DEVICE        = "RTL",
    parameter string       SIMULATION    = "false",
    parameter string       DEBUG         = "false"
) (
    input  logic                  reset_n,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_BITS-1:0]  mask,
    input  logic [DATA_BITS-1:0]  s_exp_data,
    input  logic                  s_exp_valid,
    input  logic [DATA_BITS-1:0]  s_dut_data,
    input  logic                  s_dut_valid,
    output logic                  m_running,
    output logic                  m_error,
    output logic [COUNT_BITS-1:0] m_check_count,
    output logic [COUNT_BITS-1:0] m_error_count,
    output logic                  m_first_valid,
    output logic [1:0]            m_first_kind,
    output logic [DATA_BITS-1:0]  m_first_exp,
    output logic [DATA_BITS-1:0]  m_first_dut,
    output logic [COUNT_BITS-1:0] m_first_index,
    output logic                  m_pass
);

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUN     = 2'b01;
    localparam logic [1:0] ST_STOPPED = 2'b10;

    localparam logic [1:0] KIND_NONE       = 2'b00;
    localparam logic [1:0] KIND_DATA       = 2'b01;
    localparam logic [1:0] KIND_MISSING    = 2'b10;
    localparam logic [1:0] KIND_UNEXPECTED = 2'b11;

    localparam bit STOP_EN  = (STOP_ON_ERROR == "true");
    localparam bit DEBUG_EN = (DEBUG == "true");

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    logic [1:0]            state;
    logic [COUNT_BITS-1:0] check_count;
    logic [COUNT_BITS-1:0] error_count;
    logic                  first_valid;
    logic [1:0]            first_kind;
    logic [DATA_BITS-1:0]  first_exp;
    logic [DATA_BITS-1:0]  first_dut;
    logic [COUNT_BITS-1:0] first_index;
    logic                  error_q;

    logic                  running;
    logic                  active;
    logic                  data_mismatch;
    logic [1:0]            kind;
    logic                  is_check;
    logic                  is_error;

    function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] v);
        return (v == COUNT_MAX) ? v : v + COUNT_BITS'(1);
    endfunction

    assign running       = (state == ST_RUN);
    assign data_mismatch = |((s_exp_data ^ s_dut_data) & mask);

    always_comb begin
        kind = KIND_NONE;
        if (s_exp_valid && s_dut_valid) begin
            if (data_mismatch) kind = KIND_DATA;
        end else if (s_exp_valid) begin
            kind = KIND_MISSING;
        end else if (s_dut_valid) begin
            kind = KIND_UNEXPECTED;
        end
    end

    // start wins over any same-cycle stream event, so it masks classification
    assign active   = cke && !start && running;
    assign is_check = active && s_exp_valid;
    assign is_error = active && (kind != KIND_NONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            check_count <= '0;
            error_count <= '0;
            first_valid <= 1'b0;
            first_kind  <= KIND_NONE;
            first_exp   <= '0;
            first_dut   <= '0;
            first_index <= '0;
            error_q     <= 1'b0;
        end else begin
            // error pulse is not held by cke: it drops on any cycle without a fresh error
            error_q <= is_error;
            if (cke) begin
                if (start) begin
                    state       <= ST_RUN;
                    check_count <= '0;
                    error_count <= '0;
                    first_valid <= 1'b0;
                    first_kind  <= KIND_NONE;
                    first_exp   <= '0;
                    first_dut   <= '0;
                    first_index <= '0;
                end else if (running) begin
                    if (is_check) check_count <= sat_inc(check_count);
                    if (is_error) begin
                        error_count <= sat_inc(error_count);
                        if (!first_valid) begin
                            first_valid <= 1'b1;
                            first_kind  <= kind;
                            first_exp   <= s_exp_data;
                            first_dut   <= s_dut_data;
                            first_index <= check_count;
                        end
                    end
                    if (stop || (is_error && STOP_EN)) state <= ST_STOPPED;
                end
            end
        end
    end

    assign m_running     = running;
    assign m_error       = error_q;
    assign m_check_count = check_count;
    assign m_error_count = error_count;
    assign m_first_valid = first_valid;
    assign m_first_kind  = first_kind;
    assign m_first_exp   = first_exp;
    assign m_first_dut   = first_dut;
    assign m_first_index = first_index;
    assign m_pass        = (state == ST_STOPPED) && (check_count != '0) && (error_count == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (DEBUG_EN && reset_n && is_error)
            $display("%s expected_checker: kind=%b index=%0d exp=%h dut=%h sim=%s",
                     DEVICE, kind, check_count, s_exp_data, s_dut_data, SIMULATION);
    end
`endif

endmodule

// File: tb/tb_expected_checker.sv
// Directed bench for expected_checker: stimulus pushes hand-computed responses
// into a queue, an independent negedge monitor pops and compares them.
module tb_expected_checker;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cke;
    logic       start;
    logic       stop;
    logic [7:0] mask;
    logic [7:0] s_exp_data;
    logic       s_exp_valid;
    logic [7:0] s_dut_data;
    logic       s_dut_valid;

    logic        a_run, a_err, a_fv, a_pass;
    logic [1:0]  a_fk;
    logic [7:0]  a_fe, a_fd;
    logic [31:0] a_cc, a_ec, a_fi;

    logic        b_run, b_err, b_fv, b_pass;
    logic [1:0]  b_fk;
    logic [7:0]  b_fe, b_fd;
    logic [3:0]  b_cc, b_ec, b_fi;

    logic        c_run, c_err, c_fv, c_pass;
    logic [1:0]  c_fk;
    logic [7:0]  c_fe, c_fd;
    logic [3:0]  c_cc, c_ec, c_fi;

    always #5 clk = ~clk;

    expected_checker #(.DATA_BITS(8), .COUNT_BITS(32)) u_a (
        .reset_n(reset_n), .clk(clk), .cke(cke), .start(start), .stop(stop), .mask(mask),
        .s_exp_data(s_exp_data), .s_exp_valid(s_exp_valid),
        .s_dut_data(s_dut_data), .s_dut_valid(s_dut_valid),
        .m_running(a_run), .m_error(a_err), .m_check_count(a_cc), .m_error_count(a_ec),
        .m_first_valid(a_fv), .m_first_kind(a_fk), .m_first_exp(a_fe), .m_first_dut(a_fd),
        .m_first_index(a_fi), .m_pass(a_pass)
    );

    expected_checker #(.DATA_BITS(8), .COUNT_BITS(4), .STOP_ON_ERROR("true")) u_b (
        .reset_n(reset_n), .clk(clk), .cke(cke), .start(start), .stop(stop), .mask(mask),
        .s_exp_data(s_exp_data), .s_exp_valid(s_exp_valid),
        .s_dut_data(s_dut_data), .s_dut_valid(s_dut_valid),
        .m_running(b_run), .m_error(b_err), .m_check_count(b_cc), .m_error_count(b_ec),
        .m_first_valid(b_fv), .m_first_kind(b_fk), .m_first_exp(b_fe), .m_first_dut(b_fd),
        .m_first_index(b_fi), .m_pass(b_pass)
    );

    expected_checker #(.DATA_BITS(8), .COUNT_BITS(4)) u_c (
        .reset_n(reset_n), .clk(clk), .cke(cke), .start(start), .stop(stop), .mask(mask),
        .s_exp_data(s_exp_data), .s_exp_valid(s_exp_valid),
        .s_dut_data(s_dut_data), .s_dut_valid(s_dut_valid),
        .m_running(c_run), .m_error(c_err), .m_check_count(c_cc), .m_error_count(c_ec),
        .m_first_valid(c_fv), .m_first_kind(c_fk), .m_first_exp(c_fe), .m_first_dut(c_fd),
        .m_first_index(c_fi), .m_pass(c_pass)
    );

    typedef struct {
        bit         snap;
        int         sel;
        string      name;
        bit         err;
        bit         run;
        bit         pass;
        int         cc;
        int         ec;
        bit         fv;
        bit [1:0]   fk;
        bit [7:0]   fe;
        bit [7:0]   fd;
        int         fi;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_steps  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation against the selected instance
    initial begin
        exp_t        e;
        logic        err_o, run_o, pass_o, fv_o;
        logic [1:0]  fk_o;
        logic [7:0]  fe_o, fd_o;
        logic [31:0] cc_o, ec_o, fi_o;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.sel)
                    0: begin
                        err_o = a_err; run_o = a_run; pass_o = a_pass; fv_o = a_fv; fk_o = a_fk;
                        fe_o = a_fe; fd_o = a_fd; cc_o = a_cc; ec_o = a_ec; fi_o = a_fi;
                    end
                    1: begin
                        err_o = b_err; run_o = b_run; pass_o = b_pass; fv_o = b_fv; fk_o = b_fk;
                        fe_o = b_fe; fd_o = b_fd; cc_o = {28'd0, b_cc}; ec_o = {28'd0, b_ec};
                        fi_o = {28'd0, b_fi};
                    end
                    default: begin
                        err_o = c_err; run_o = c_run; pass_o = c_pass; fv_o = c_fv; fk_o = c_fk;
                        fe_o = c_fe; fd_o = c_fd; cc_o = {28'd0, c_cc}; ec_o = {28'd0, c_ec};
                        fi_o = {28'd0, c_fi};
                    end
                endcase
                chk($sformatf("%s.m_error", e.name), {31'd0, err_o}, {31'd0, e.err});
                if (e.snap) begin
                    chk($sformatf("%s.running", e.name), {31'd0, run_o}, {31'd0, e.run});
                    chk($sformatf("%s.pass", e.name), {31'd0, pass_o}, {31'd0, e.pass});
                    chk($sformatf("%s.check_count", e.name), cc_o, e.cc);
                    chk($sformatf("%s.error_count", e.name), ec_o, e.ec);
                    chk($sformatf("%s.first_valid", e.name), {31'd0, fv_o}, {31'd0, e.fv});
                    chk($sformatf("%s.first_kind", e.name), {30'd0, fk_o}, {30'd0, e.fk});
                    chk($sformatf("%s.first_exp", e.name), {24'd0, fe_o}, {24'd0, e.fe});
                    chk($sformatf("%s.first_dut", e.name), {24'd0, fd_o}, {24'd0, e.fd});
                    chk($sformatf("%s.first_index", e.name), fi_o, e.fi);
                end
            end
        end
    end

    // Entered at posedge+1; drives one cycle and queues the expected m_error pulse
    task automatic step(input int sel, input bit e_err, input bit ev, input logic [7:0] ed,
                        input bit dv, input logic [7:0] dd, input bit st, input bit sp);
        exp_t e;
        s_exp_valid = ev; s_exp_data = ed;
        s_dut_valid = dv; s_dut_data = dd;
        start = st; stop = sp;
        @(posedge clk);
        #1;
        e = '{snap: 1'b0, sel: sel, name: $sformatf("step%0d", n_steps), err: e_err,
              run: 1'b0, pass: 1'b0, cc: 0, ec: 0, fv: 1'b0, fk: 2'b00, fe: 8'h00, fd: 8'h00, fi: 0};
        q.push_back(e);
        n_steps++;
        start = 1'b0; stop = 1'b0;
        s_exp_valid = 1'b0; s_dut_valid = 1'b0;
    endtask

    task automatic snap(input string nm, input int sel, input bit err, input bit run, input bit pass,
                        input int cc, input int ec, input bit fv, input bit [1:0] fk,
                        input bit [7:0] fe, input bit [7:0] fd, input int fi);
        exp_t e;
        e = '{snap: 1'b1, sel: sel, name: nm, err: err, run: run, pass: pass, cc: cc, ec: ec,
              fv: fv, fk: fk, fe: fe, fd: fd, fi: fi};
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; cke = 1'b1; start = 1'b0; stop = 1'b0; mask = 8'hFF;
        s_exp_data = '0; s_exp_valid = 1'b0; s_dut_data = '0; s_dut_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        snap("reset_a", 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        snap("reset_b", 1, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        snap("reset_c", 2, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // clean run of ten matching pairs
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(i), 1, 8'(i), 0, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        snap("clean", 0, 0, 0, 1, 10, 0, 0, 2'b00, 8'h00, 8'h00, 0);

        // data mismatch on pair 4
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) step(0, 1, 1, 8'h55, 1, 8'h54, 0, 0);
            else        step(0, 0, 1, 8'(i), 1, 8'(i), 0, 0);
        end
        snap("mismatch", 0, 0, 1, 0, 10, 1, 1, 2'b01, 8'h55, 8'h54, 4);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        snap("mismatch_stop", 0, 0, 0, 0, 10, 1, 1, 2'b01, 8'h55, 8'h54, 4);

        // same pair, differing bit masked off
        mask = 8'hFE;
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        step(0, 0, 1, 8'h55, 1, 8'h54, 0, 0);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        snap("masked", 0, 0, 0, 1, 1, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        mask = 8'hFF;

        // missing DUT valid on pair 2, lone DUT valid later
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        step(0, 0, 1, 8'h10, 1, 8'h10, 0, 0);
        step(0, 0, 1, 8'h11, 1, 8'h11, 0, 0);
        step(0, 1, 1, 8'h22, 0, 8'h00, 0, 0);
        step(0, 0, 1, 8'h13, 1, 8'h13, 0, 0);
        step(0, 1, 0, 8'h00, 1, 8'h99, 0, 0);
        step(0, 0, 1, 8'h15, 1, 8'h15, 0, 0);
        snap("missing", 0, 0, 1, 0, 5, 2, 1, 2'b10, 8'h22, 8'h00, 2);
        step(0, 0, 0, 8'h00, 0, 8'h00, 0, 1);

        // STOP_ON_ERROR instance: mismatch on pair 3 freezes it
        step(1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) step(1, 1, 1, 8'h03, 1, 8'h13, 0, 0);
            else        step(1, 0, 1, 8'(i), 1, 8'(i), 0, 0);
        end
        snap("stop_on_err", 1, 0, 0, 0, 4, 1, 1, 2'b01, 8'h03, 8'h13, 3);
        step(1, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        snap("restart", 1, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);

        // cke low blocks counting; start+stop together restarts
        step(0, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        cke = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(i), 1, 8'(i + 8'h80), 0, 0);
        cke = 1'b1;
        snap("cke_low", 0, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        step(0, 0, 1, 8'h07, 1, 8'h07, 0, 0);
        step(0, 0, 1, 8'h40, 1, 8'h41, 1, 1);
        snap("start_stop", 0, 0, 1, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);

        // asynchronous reset mid-run, off the clock edge
        step(0, 1, 1, 8'h01, 1, 8'h02, 0, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        snap("async_rst_a", 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        snap("async_rst_b", 1, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        snap("async_rst_c", 2, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 1, 8'h01, 1, 8'h02, 0, 0);
        snap("idle_ignores", 0, 0, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 0);

        // 4-bit counters saturate at 15
        step(2, 0, 0, 8'h00, 0, 8'h00, 1, 0);
        for (int i = 0; i < 20; i++) step(2, 1, 1, 8'hA0, 1, 8'h0A, 0, 0);
        snap("saturate", 2, 1, 1, 0, 15, 15, 1, 2'b01, 8'hA0, 8'h0A, 0);
        step(2, 0, 0, 8'h00, 0, 8'h00, 0, 1);
        snap("sat_stop", 2, 0, 0, 0, 15, 15, 1, 2'b01, 8'hA0, 8'h0A, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
